// File: rtl/xalu_seq.sv
// Nibble-serial ALU sequencer: drives an external 4-bit ALU slice once per
// nibble and assembles a W-bit result with carry, zero and equality flags.
module xalu_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2:0]             op,
    input  logic                   com,
    input  logic                   cin,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   zero,
    output logic                   equ,
    output logic [3:0]             slice_a,
    output logic [3:0]             slice_b,
    output logic [2:0]             slice_f,
    output logic                   slice_com,
    output logic                   slice_ci_left,
    output logic                   slice_ci_right,
    input  logic [3:0]             slice_d,
    input  logic                   slice_co_left,
    input  logic                   slice_co_right,
    input  logic                   slice_equ
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_AND, OP_OR, OP_XOR, OP_PASSA, OP_PASSB, OP_SHR, OP_SHL
    } op_t;

    state_t         state, state_nx;
    op_t            op_q;
    logic           com_q, cin_q;
    logic [W-1:0]   a_q, b_q, acc, acc_nx;
    logic [IW-1:0]  idx, pos;
    logic           carry, carry_in, carry_nx, equ_acc;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (idx == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // SHR walks the word MSB-first so its shift-in ripples downward.
    assign pos      = (op_q == OP_SHR) ? LAST - idx : idx;
    assign carry_in = (idx == '0) ? cin_q : carry;
    assign carry_nx = (op_q == OP_SHR) ? slice_co_right : slice_co_left;

    always_comb begin
        slice_a        = '0;
        slice_b        = '0;
        slice_f        = '0;
        slice_com      = 1'b0;
        slice_ci_left  = 1'b0;
        slice_ci_right = 1'b0;
        if (state == RUN) begin
            slice_a   = a_q[4*pos +: 4];
            slice_b   = b_q[4*pos +: 4];
            slice_f   = op_q;
            slice_com = com_q;
            unique case (op_q)
                OP_ADD, OP_SHL: slice_ci_right = carry_in;
                OP_SHR:         slice_ci_left  = carry_in;
                default:        ;
            endcase
        end
    end

    always_comb begin
        acc_nx             = acc;
        acc_nx[4*pos +: 4] = slice_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            equ_acc <= 1'b0;
            acc     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            com_q   <= 1'b0;
            cin_q   <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            zero    <= 1'b0;
            equ     <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: if (start) begin
                    a_q     <= a;
                    b_q     <= b;
                    op_q    <= op_t'(op);
                    com_q   <= com;
                    cin_q   <= cin;
                    idx     <= '0;
                    carry   <= 1'b0;
                    equ_acc <= 1'b1;
                    acc     <= '0;
                end
                RUN: begin
                    idx     <= idx + 1'b1;
                    carry   <= carry_nx;
                    equ_acc <= equ_acc & slice_equ;
                    acc     <= acc_nx;
                    // Visible outputs only change on the final pass so an abort leaves no partial word.
                    if (idx == LAST) begin
                        result <= acc_nx;
                        zero   <= (acc_nx == '0);
                        equ    <= equ_acc & slice_equ;
                        cout   <= (op_q inside {OP_ADD, OP_SHL, OP_SHR}) ? carry_nx : 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xalu_seq.sv
// Bench for xalu_seq paired with a behavioural 4-bit ALU slice; word-level
// reference model checked every cycle, plus directed literal cases.
module tb_xalu_seq;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    logic          clk = 1'b0;
    logic          rst, start, com, cin;
    logic [2:0]    op;
    logic [W-1:0]  a, b;
    logic          busy, done, cout, zero, equ;
    logic [W-1:0]  result;
    logic [3:0]    slice_a, slice_b, slice_d;
    logic [2:0]    slice_f;
    logic          slice_com, slice_ci_left, slice_ci_right;
    logic          slice_co_left, slice_co_right, slice_equ;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xalu_seq #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .com(com), .cin(cin),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .cout(cout), .zero(zero), .equ(equ),
        .slice_a(slice_a), .slice_b(slice_b), .slice_f(slice_f),
        .slice_com(slice_com), .slice_ci_left(slice_ci_left),
        .slice_ci_right(slice_ci_right), .slice_d(slice_d),
        .slice_co_left(slice_co_left), .slice_co_right(slice_co_right),
        .slice_equ(slice_equ)
    );

    // 4-bit ALU slice
    logic [4:0] s_sum;
    logic [3:0] s_raw;
    always_comb begin
        s_sum          = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_ci_right};
        s_raw          = '0;
        slice_co_left  = 1'b0;
        slice_co_right = 1'b0;
        case (slice_f)
            3'd0: begin s_raw = s_sum[3:0]; slice_co_left = s_sum[4]; end
            3'd1: s_raw = slice_a & slice_b;
            3'd2: s_raw = slice_a | slice_b;
            3'd3: s_raw = slice_a ^ slice_b;
            3'd4: s_raw = slice_a;
            3'd5: s_raw = slice_b;
            3'd6: begin s_raw = {slice_ci_left, slice_a[3:1]}; slice_co_right = slice_a[0]; end
            default: begin s_raw = {slice_a[2:0], slice_ci_right}; slice_co_left = slice_a[3]; end
        endcase
        slice_d   = slice_com ? ~s_raw : s_raw;
        slice_equ = (slice_a == slice_b);
    end

    // Whole-word result: {carry/shift-out, complemented result}
    function automatic logic [W:0] calc(input logic [2:0] f, input logic c, input logic ci,
                                        input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         co;
        s  = '0;
        r  = '0;
        co = 1'b0;
        case (f)
            3'd0: begin s = {1'b0, x} + {1'b0, y} + (W+1)'(ci); r = s[W-1:0]; co = s[W]; end
            3'd1: r = x & y;
            3'd2: r = x | y;
            3'd3: r = x ^ y;
            3'd4: r = x;
            3'd5: r = y;
            3'd6: begin r = {ci, x[W-1:1]}; co = x[0]; end
            default: begin r = {x[W-2:0], ci}; co = x[W-1]; end
        endcase
        if (c) r = ~r;
        return {co, r};
    endfunction

    // Reference model: m_cnt = cycles left until idle (N+1 .. 1), 1 means done
    int           m_cnt = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic [2:0]   m_op = '0;
    logic         m_com = 1'b0, m_cin = 1'b0, m_cout = 1'b0, m_zero = 1'b0, m_equ = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt  <= 0;
            m_res  <= '0;
            m_cout <= 1'b0;
            m_zero <= 1'b0;
            m_equ  <= 1'b0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_a <= a; m_b <= b; m_op <= op; m_com <= com; m_cin <= cin;
                m_cnt <= N + 1;
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) begin
                {m_cout, m_res} <= calc(m_op, m_com, m_cin, m_a, m_b);
                m_zero          <= (W'(calc(m_op, m_com, m_cin, m_a, m_b)) == '0);
                m_equ           <= (m_a == m_b);
            end
        end
    end

    // Carry into pass p, derived from whole-word arithmetic on the latched operands
    function automatic void exp_ci(input int p, output logic cl, output logic cr);
        longint unsigned msk, s;
        cl = 1'b0;
        cr = 1'b0;
        case (m_op)
            3'd0: begin
                msk = (64'd1 << (4*p)) - 64'd1;
                s   = (longint'(m_a) & msk) + (longint'(m_b) & msk) + longint'(m_cin);
                cr  = 1'((s >> (4*p)) & 64'd1);
            end
            3'd7: if (p == 0) cr = m_cin; else cr = m_a[4*p-1];
            3'd6: if (p == 0) cl = m_cin; else cl = m_a[4*(N-p)];
            default: ;
        endcase
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        int   p, pos;
        logic cl, cr;
        if (cyc > 0) begin
            chk("busy",   W'(busy),   W'(m_cnt > 0));
            chk("done",   W'(done),   W'(m_cnt == 1));
            chk("result", result,     m_res);
            chk("cout",   W'(cout),   W'(m_cout));
            chk("zero",   W'(zero),   W'(m_zero));
            chk("equ",    W'(equ),    W'(m_equ));
            if (m_cnt >= 2) begin
                p   = N + 1 - m_cnt;
                pos = (m_op == 3'd6) ? N - 1 - p : p;
                exp_ci(p, cl, cr);
                chk("slice_a",  W'(slice_a),   (m_a >> (4*pos)) & W'(4'hF));
                chk("slice_b",  W'(slice_b),   (m_b >> (4*pos)) & W'(4'hF));
                chk("slice_f",  W'(slice_f),   W'(m_op));
                chk("slice_com", W'(slice_com), W'(m_com));
                chk("slice_ci_left",  W'(slice_ci_left),  W'(cl));
                chk("slice_ci_right", W'(slice_ci_right), W'(cr));
            end else begin
                chk("slice_quiet", W'({slice_a, slice_b, slice_f, slice_com,
                                       slice_ci_left, slice_ci_right}), '0);
            end
        end
    end

    // Issue one op when idle; returns cycles from start edge to done and the cycle stamp
    task automatic run_op(input logic [2:0] f, input logic c, input logic ci,
                          input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output int t_done);
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        op = f; com = c; cin = ci; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); op = 3'($urandom); com = 1'($urandom); cin = 1'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat <= 20);
        t_done = cyc;
    endtask

    initial begin
        int lat, t1, t2, dn;
        rst = 1'b1; start = 1'b0; op = '0; com = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_op(3'd0, 1'b0, 1'b0, 16'h00FF, 16'h0001, lat, t1);
        chk("add1_result", result, 16'h0100);
        chk("add1_cout",   W'(cout), '0);
        chk("add1_zero",   W'(zero), '0);
        chk("add1_equ",    W'(equ),  '0);
        chk("add1_latency", W'(lat), W'(N + 1));

        run_op(3'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, lat, t1);
        chk("add2_result", result, 16'h0000);
        chk("add2_cout",   W'(cout), 16'd1);
        chk("add2_zero",   W'(zero), 16'd1);

        run_op(3'd6, 1'b0, 1'b1, 16'h8001, 16'h0000, lat, t1);
        chk("shr_result", result, 16'hC000);
        chk("shr_cout",   W'(cout), 16'd1);

        run_op(3'd7, 1'b0, 1'b0, 16'h8001, 16'h0000, lat, t1);
        chk("shl_result", result, 16'h0002);
        chk("shl_cout",   W'(cout), 16'd1);

        run_op(3'd3, 1'b1, 1'b0, 16'h1234, 16'h1234, lat, t1);
        chk("xorc_result", result, 16'hFFFF);
        chk("xorc_equ",    W'(equ),  16'd1);
        chk("xorc_zero",   W'(zero), '0);
        chk("xorc_cout",   W'(cout), '0);

        // Abort: restart during RUN is ignored, reset in the third RUN cycle
        @(posedge clk); #1;
        op = 3'd0; com = 1'b0; cin = 1'b0; a = 16'h1234; b = 16'h0001; start = 1'b1;
        @(posedge clk); #1;
        a = 16'h5555;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy",   W'(busy), '0);
        chk("abort_result", result,   16'h0000);
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort_no_done", W'(dn), '0);

        // Back-to-back: second start in the idle cycle right after done
        run_op(3'd0, 1'b0, 1'b1, 16'h1234, 16'h4321, lat, t1);
        chk("b2b1_result", result, 16'h5556);
        run_op(3'd1, 1'b0, 1'b0, 16'hF0F0, 16'h3C3C, lat, t2);
        chk("b2b2_result", result, 16'h3030);
        chk("b2b_gap", W'(t2 - t1), W'(N + 2));

        repeat (3000) begin
            @(posedge clk); #1;
            rst   = ($urandom_range(0, 49) == 0);
            start = 1'($urandom);
            op    = 3'($urandom);
            com   = 1'($urandom);
            cin   = 1'($urandom);
            a     = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
            b     = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        repeat (10) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xalu_seq.md
XALU_SEQ -- requirements
Module: xalu_seq

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slice passes per operation; operand width W = 4*NIBBLES.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  operation request, sampled only in IDLE.
REQ-005 Port: op  input  3  function code: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL.
REQ-006 Port: com  input  1  ones-complement output mode for the whole operation.
REQ-007 Port: cin  input  1  carry-in (ADD), shift-in at LSB (SHL) or at MSB (SHR).
REQ-008 Port: a, b  input  W  operands.
REQ-009 Port: busy  output  1  high whenever state is not IDLE.
REQ-010 Port: done  output  1  one-cycle completion pulse.
REQ-011 Port: result  output  W  completed result, held until the next accepted start.
REQ-012 Port: cout, zero, equ  output  1 each  final carry/shift-out, result==0, a==b.
REQ-013 Port: slice_a, slice_b  output  4  nibble operands driven to the ALU slice.
REQ-014 Port: slice_f  output  3  slice function code; slice_com  output  1  slice complement mode.
REQ-015 Port: slice_ci_left, slice_ci_right  output  1 each  slice carry inputs.
REQ-016 Port: slice_d  input  4; slice_co_left, slice_co_right, slice_equ  input  1 each  slice outputs (combinational).

Function
REQ-017 States IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after NIBBLES RUN cycles; DONE->IDLE unconditionally after one cycle.
REQ-018 On accepted start, a, b, op, com and cin are latched; later input changes have no effect until the next accepted start.
REQ-019 start is ignored in RUN and DONE; start in the cycle after DONE (IDLE) is accepted, giving back-to-back operation.
REQ-020 A nibble index counts 0..NIBBLES-1 in RUN; slice_f = latched op and slice_com = latched com.
REQ-021 For ops 0-5 and 7, RUN pass i drives nibble i (LSB first); for SHR, pass i drives nibble NIBBLES-1-i (MSB first).
REQ-022 ADD/SHL: pass 0 slice_ci_right = cin; later passes slice_ci_right = carry register loaded from slice_co_left; slice_ci_left = 0.
REQ-023 SHR: pass 0 slice_ci_left = cin; later passes slice_ci_left = carry register loaded from slice_co_right; slice_ci_right = 0.
REQ-024 Ops 1-5: both slice carry inputs = 0.
REQ-025 Each RUN edge writes slice_d into the corresponding result nibble and ANDs slice_equ into an equality accumulator.
REQ-026 cout = final carry register for ADD/SHL/SHR, 0 for other ops; zero = (result == 0) after complement; equ = accumulated slice_equ.
REQ-027 done is high only in DONE, exactly NIBBLES+1 cycles after the start cycle; result/cout/zero/equ update on the edge entering DONE and hold through IDLE.
REQ-028 In IDLE and DONE, slice_a, slice_b, slice_f, slice_com and both slice carries drive 0.

Reset
REQ-029 rst=1 at an edge forces IDLE, clears the nibble index, carry register and equality accumulator, and sets busy=0, done=0, result=0, cout=0, zero=0, equ=0, regardless of state.
REQ-030 rst during RUN aborts the operation: no done pulse and no partial result visible.
REQ-031 rst has priority over start in the same cycle.

Verification
REQ-032 Bench pairs the DUT with the 4-bit ALU slice; all values assume NIBBLES=4.
REQ-033 ADD a=0x00FF b=0x0001 cin=0 -> result 0x0100, cout 0, zero 0, equ 0; done exactly 5 cycles after start.
REQ-034 ADD a=0xFFFF b=0x0001 cin=0 -> result 0x0000, cout 1, zero 1.
REQ-035 SHR a=0x8001 cin=1 -> result 0xC000, cout 1; SHL a=0x8001 cin=0 -> result 0x0002, cout 1.
REQ-036 XOR com=1 a=b=0x1234 -> result 0xFFFF, equ 1, zero 0, cout 0.
REQ-037 Start ADD, assert start again during RUN, then rst on 3rd RUN cycle -> second start ignored, busy 0 next cycle, done never pulses, result 0x0000.
REQ-038 Two back-to-back starts (second in the cycle after done) -> both results correct, done pulses 6 cycles apart.
